hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
//  Pipeline hazard and stall controller for the 5-stage MIPS core; producer of the hazard_detected
//  signal consumed by the main control decoder, which zeroes ID control bits to form a bubble.
//  Detects load-use and ID-stage branch-operand hazards and gates PC/IF-ID writes.
//  Freezes the whole pipeline while data memory is busy, using a wait FSM with a timeout.
//  Keeps saturating bubble/freeze performance counters.
// PARAMETERS
//  REG_W     5   register specifier width
//  WAIT_MAX  15  max consecutive MEM_WAIT cycles before timeout (>=1)
//  CNT_W     16  width of the performance counters
// PORTS
//  clk             in   1      system clock, rising edge
//  rst             in   1      asynchronous, active-high reset
//  id_opcode       in   6      opcode of instruction in ID
//  id_rs, id_rt    in   REG_W  source specifiers in ID
//  ex_mem_read     in   1      ID/EX MemRead (load in EX)
//  ex_reg_write    in   1      ID/EX RegWrite
//  ex_dst          in   REG_W  EX destination register (after RegDst mux)
//  mem_mem_read    in   1      EX/MEM MemRead (load in MEM)
//  mem_dst         in   REG_W  MEM destination register
//  dmem_req        in   1      data-memory access issued this cycle by MEM stage
//  dmem_ready      in   1      data memory completes the access this cycle
//  hazard_detected out  1      insert bubble into ID/EX (to control decoder)
//  pc_write        out  1      PC write enable
//  ifid_write      out  1      IF/ID write enable
//  pipe_freeze     out  1      hold ID/EX, EX/MEM, MEM/WB (no update)
//  mem_timeout     out  1      sticky: memory wait exceeded WAIT_MAX
//  bubble_count    out  CNT_W  cycles with hazard_detected=1, saturating
//  freeze_count    out  CNT_W  cycles with pipe_freeze=1, saturating
// BEHAVIOUR
//  uses_rt = opcode in {000000 R-type, 000100 BEQ, 101011 SW}; is_beq = opcode==000100.
//  Register 0 never matches (a specifier of 0 is never a hazard).
//  load_use = ex_mem_read & ex_dst==id_rs | (uses_rt & ex_dst==id_rt).
//  br_haz = is_beq & ((ex_reg_write & ex_dst matches rs/rt) | (mem_mem_read & mem_dst matches rs/rt)).
//  FSM states RUN, MEM_WAIT, TIMEOUT (registered); wait_cnt is a registered counter.
//  freeze = (RUN & dmem_req & ~dmem_ready) | (MEM_WAIT & ~dmem_ready) | TIMEOUT.
//  Combinational outputs: pipe_freeze=freeze; hazard_detected=(load_use|br_haz)&~freeze;
//   pc_write=ifid_write=~freeze & ~(load_use|br_haz). Freeze dominates bubbles (no bubble while frozen).
//  RUN: dmem_req & ~dmem_ready -> MEM_WAIT, wait_cnt<=1; else stay.
//  MEM_WAIT: dmem_ready -> RUN (freeze drops the same cycle), wait_cnt<=0;
//   else if wait_cnt==WAIT_MAX -> TIMEOUT, mem_timeout<=1; else wait_cnt+1.
//  TIMEOUT: terminal until rst; pipeline stays frozen; mem_timeout holds 1.
//  Load-use costs exactly 1 bubble (next cycle the load is in MEM; no match on ex_* fields).
//  BEQ after ALU op: 1 bubble; BEQ directly after LW: 2 bubbles (EX match, then MEM match).
//  Counters increment by 1 per qualifying cycle, hold at all-ones; freeze and bubble never both count.
//  During rst: state=RUN, wait_cnt=0, mem_timeout=0, counters=0; combinational outputs forced
//   pc_write=0, ifid_write=0, hazard_detected=0, pipe_freeze=1. Reset mid-MEM_WAIT returns to RUN.
// TESTING
//  LW $2 in EX (ex_mem_read=1,ex_dst=2), ID ADD rs=2 -> hazard_detected=1, pc_write=0 one cycle; bubble_count=1.
//  LW $2 in EX, ID ADDI rt=2 (rt not a source) -> no hazard; ex_dst=0 with id_rs=0 -> no hazard.
//  LW $5 then BEQ rs=5 -> hazard_detected high for 2 consecutive cycles, then pc_write=1.
//  dmem_req=1, dmem_ready low 3 cycles -> pipe_freeze=1 for 3 cycles, freeze_count=3, back to RUN.
//  dmem_ready held 0 with WAIT_MAX=4 -> after 5 frozen cycles mem_timeout=1, stays frozen; rst clears all.
//  Load-use hazard present while memory busy -> hazard_detected=0, pipe_freeze=1; bubble issued after release.

Source files
------------

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use/branch hazard detection, memory-wait freeze FSM and stall counters

// Counter that stops at all-ones instead of wrapping.
module hazard_sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Count qualifying cycles and hold once the counter is full.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

module hazard_unit #(
  parameter int REG_W    = 5,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [5:0]       i_id_opcode,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_ex_mem_read,
  input  logic             i_ex_reg_write,
  input  logic [REG_W-1:0] i_ex_dst,
  input  logic             i_mem_mem_read,
  input  logic [REG_W-1:0] i_mem_dst,
  input  logic             i_dmem_req,
  input  logic             i_dmem_ready,
  output logic             o_hazard_detected,
  output logic             o_pc_write,
  output logic             o_ifid_write,
  output logic             o_pipe_freeze,
  output logic             o_mem_timeout,
  output logic [CNT_W-1:0] o_bubble_count,
  output logic [CNT_W-1:0] o_freeze_count
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Wide enough to hold WAIT_MAX itself.
  localparam int                WCNT_W     = $clog2(WAIT_MAX + 1);
  localparam logic [WCNT_W-1:0] WAIT_LIMIT = WCNT_W'(WAIT_MAX);
  localparam logic [WCNT_W-1:0] WAIT_ONE   = WCNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_TIMEOUT  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WCNT_W-1:0] r_wait_cnt;
  logic [WCNT_W-1:0] w_wait_cnt_nxt;
  logic              r_mem_timeout;
  logic              w_timeout_set;
  logic              w_freeze;

  logic              w_uses_rt;
  logic              w_is_beq;
  logic              w_load_use;
  logic              w_br_haz;
  logic              w_stall_req;

  // Register $0 is hardwired to zero, so it can never carry a dependency.
  function automatic logic reg_match(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  // Decode which ID instructions read rt and which resolve a branch in ID.
  always_comb begin
    w_uses_rt = (i_id_opcode == OP_RTYPE) || (i_id_opcode == OP_BEQ) || (i_id_opcode == OP_SW);
    w_is_beq  = (i_id_opcode == OP_BEQ);
  end

  // Hazard detection: a load in EX feeding ID, or a BEQ whose operands are still in flight.
  always_comb begin
    w_load_use = i_ex_mem_read &&
                 (reg_match(i_ex_dst, i_id_rs) || (w_uses_rt && reg_match(i_ex_dst, i_id_rt)));
    w_br_haz   = w_is_beq &&
                 ((i_ex_reg_write && (reg_match(i_ex_dst, i_id_rs) || reg_match(i_ex_dst, i_id_rt))) ||
                  (i_mem_mem_read && (reg_match(i_mem_dst, i_id_rs) || reg_match(i_mem_dst, i_id_rt))));
    w_stall_req = w_load_use || w_br_haz;
  end

  // Memory-wait FSM next state; freeze is asserted in the cycle the miss is first seen.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_timeout_set  = 1'b0;
    w_freeze       = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (i_dmem_req && !i_dmem_ready) begin
          w_freeze       = 1'b1;
          w_state_nxt    = ST_MEM_WAIT;
          w_wait_cnt_nxt = WAIT_ONE;
        end
      end
      ST_MEM_WAIT: begin
        if (i_dmem_ready) begin
          w_state_nxt    = ST_RUN;
          w_wait_cnt_nxt = '0;
        end else begin
          w_freeze = 1'b1;
          if (r_wait_cnt == WAIT_LIMIT) begin
            w_state_nxt   = ST_TIMEOUT;
            w_timeout_set = 1'b1;
          end else begin
            w_wait_cnt_nxt = r_wait_cnt + WAIT_ONE;
          end
        end
      end
      ST_TIMEOUT: begin
        w_freeze = 1'b1;
      end
      default: begin
        w_state_nxt    = ST_RUN;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  // FSM state, wait counter and sticky timeout flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_mem_timeout <= r_mem_timeout | w_timeout_set;
    end
  end

  // Pipeline control: freeze wins over bubbles; everything held while in reset.
  always_comb begin
    if (i_rst) begin
      o_pipe_freeze     = 1'b1;
      o_hazard_detected = 1'b0;
      o_pc_write        = 1'b0;
      o_ifid_write      = 1'b0;
    end else begin
      o_pipe_freeze     = w_freeze;
      o_hazard_detected = w_stall_req && !w_freeze;
      o_pc_write        = !w_freeze && !w_stall_req;
      o_ifid_write      = !w_freeze && !w_stall_req;
    end
  end

  assign o_mem_timeout = r_mem_timeout;

  hazard_sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (o_hazard_detected),
    .o_count (o_bubble_count)
  );

  hazard_sat_counter #(.W(CNT_W)) u_freeze_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (o_pipe_freeze),
    .o_count (o_freeze_count)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - scoreboard bench for hazard_unit
module tb_hazard_unit;

  localparam int WMAX = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  logic          i_clk;
  logic          i_rst;
  logic [5:0]    i_id_opcode;
  logic [4:0]    i_id_rs, i_id_rt, i_ex_dst, i_mem_dst;
  logic          i_ex_mem_read, i_ex_reg_write, i_mem_mem_read, i_dmem_req, i_dmem_ready;
  logic          o_hazard_detected, o_pc_write, o_ifid_write, o_pipe_freeze, o_mem_timeout;
  logic [CW-1:0] o_bubble_count, o_freeze_count;

  hazard_unit #(.REG_W(5), .WAIT_MAX(WMAX), .CNT_W(CW)) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_id_opcode       (i_id_opcode),
    .i_id_rs           (i_id_rs),
    .i_id_rt           (i_id_rt),
    .i_ex_mem_read     (i_ex_mem_read),
    .i_ex_reg_write    (i_ex_reg_write),
    .i_ex_dst          (i_ex_dst),
    .i_mem_mem_read    (i_mem_mem_read),
    .i_mem_dst         (i_mem_dst),
    .i_dmem_req        (i_dmem_req),
    .i_dmem_ready      (i_dmem_ready),
    .o_hazard_detected (o_hazard_detected),
    .o_pc_write        (o_pc_write),
    .o_ifid_write      (o_ifid_write),
    .o_pipe_freeze     (o_pipe_freeze),
    .o_mem_timeout     (o_mem_timeout),
    .o_bubble_count    (o_bubble_count),
    .o_freeze_count    (o_freeze_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    int hz;
    int pcw;
    int frz;
    int to;
    int bub;
    int fc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // reference state: 0 = running, 1 = waiting on memory, 2 = timed out
  int m_state, m_wait, m_to, m_bub, m_fc;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_wait = 0; m_to = 0; m_bub = 0; m_fc = 0;
  endtask

  function automatic bit same_nz(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  task automatic model_eval(output exp_t e);
    bit rt_src, lu, br, fz;
    rt_src = (i_id_opcode == OP_R) || (i_id_opcode == OP_BEQ) || (i_id_opcode == OP_SW);
    lu = i_ex_mem_read && (same_nz(i_ex_dst, i_id_rs) || (rt_src && same_nz(i_ex_dst, i_id_rt)));
    br = (i_id_opcode == OP_BEQ) &&
         ((i_ex_reg_write && (same_nz(i_ex_dst, i_id_rs) || same_nz(i_ex_dst, i_id_rt))) ||
          (i_mem_mem_read && (same_nz(i_mem_dst, i_id_rs) || same_nz(i_mem_dst, i_id_rt))));
    if (m_state == 2)      fz = 1'b1;
    else if (m_state == 1) fz = !i_dmem_ready;
    else                   fz = i_dmem_req && !i_dmem_ready;
    e.hz  = (lu || br) && !fz;
    e.pcw = !fz && !(lu || br);
    e.frz = fz;
    e.to  = m_to;
    e.bub = m_bub;
    e.fc  = m_fc;
  endtask

  task automatic model_advance(input exp_t e);
    if (e.hz != 0 && m_bub < CMAX) m_bub++;
    if (e.frz != 0 && m_fc < CMAX) m_fc++;
    if (m_state == 0) begin
      if (i_dmem_req && !i_dmem_ready) begin m_state = 1; m_wait = 1; end
    end else if (m_state == 1) begin
      if (i_dmem_ready)        begin m_state = 0; m_wait = 0; end
      else if (m_wait == WMAX) begin m_state = 2; m_to = 1; end
      else                     m_wait++;
    end
  endtask

  task automatic compare_pop();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("hazard_detected", int'(o_hazard_detected), e.hz);
      chk("pc_write", int'(o_pc_write), e.pcw);
      chk("ifid_write", int'(o_ifid_write), e.pcw);
      chk("pipe_freeze", int'(o_pipe_freeze), e.frz);
      chk("mem_timeout", int'(o_mem_timeout), e.to);
      chk("bubble_count", int'(o_bubble_count), e.bub);
      chk("freeze_count", int'(o_freeze_count), e.fc);
    end
  endtask

  // one cycle: entered and left just after a rising edge
  task automatic step(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic exmr, input logic exrw, input logic [4:0] exd,
                      input logic memmr, input logic [4:0] memd,
                      input logic req, input logic rdy);
    exp_t e;
    i_id_opcode = op;  i_id_rs = rs; i_id_rt = rt;
    i_ex_mem_read = exmr; i_ex_reg_write = exrw; i_ex_dst = exd;
    i_mem_mem_read = memmr; i_mem_dst = memd;
    i_dmem_req = req; i_dmem_ready = rdy;
    model_eval(e);
    sb.push_back(e);
    @(negedge i_clk);
    compare_pop();
    @(posedge i_clk);
    model_advance(e);
    #1;
  endtask

  task automatic idle();
    step(OP_R, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
  endtask

  task automatic do_reset(input string tag);
    i_rst = 1'b1;
    model_reset();
    #1;
    chk({tag, "_pcw"}, int'(o_pc_write), 0);
    chk({tag, "_ifw"}, int'(o_ifid_write), 0);
    chk({tag, "_hz"}, int'(o_hazard_detected), 0);
    chk({tag, "_frz"}, int'(o_pipe_freeze), 1);
    chk({tag, "_to"}, int'(o_mem_timeout), 0);
    chk({tag, "_bub"}, int'(o_bubble_count), 0);
    chk({tag, "_fc"}, int'(o_freeze_count), 0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  initial begin
    logic [5:0] ops [5];
    ops[0] = OP_R; ops[1] = OP_BEQ; ops[2] = OP_SW; ops[3] = OP_ADDI; ops[4] = OP_LW;
    i_rst = 1'b1;
    i_id_opcode = OP_R; i_id_rs = '0; i_id_rt = '0; i_ex_dst = '0; i_mem_dst = '0;
    i_ex_mem_read = 1'b0; i_ex_reg_write = 1'b0; i_mem_mem_read = 1'b0;
    i_dmem_req = 1'b0; i_dmem_ready = 1'b1;
    model_reset();
    @(posedge i_clk);
    #1;
    do_reset("rst0");

    // load-use: LW $2 in EX, ADD rs=2 in ID -> one bubble
    step(OP_R, 5'd2, 5'd3, 1'b1, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1);
    step(OP_R, 5'd2, 5'd3, 1'b0, 1'b0, 5'd0, 1'b1, 5'd2, 1'b0, 1'b1);
    chk("lu_bubble_total", int'(o_bubble_count), 1);

    // ADDI reads only rs; $0 never matches
    step(OP_ADDI, 5'd7, 5'd2, 1'b1, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1);
    step(OP_R, 5'd0, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);

    // BEQ right after LW $5: two bubbles then release
    step(OP_BEQ, 5'd5, 5'd6, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b1);
    step(OP_BEQ, 5'd5, 5'd6, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b1);
    step(OP_BEQ, 5'd5, 5'd6, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    chk("beq_lw_release_pcw", int'(o_pc_write), 1);
    chk("beq_lw_bubble_total", int'(o_bubble_count), 3);

    // BEQ after ALU op on rt: one bubble; SW stalls on rt from a load
    step(OP_BEQ, 5'd1, 5'd8, 1'b0, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 1'b1);
    step(OP_BEQ, 5'd1, 5'd8, 1'b0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b0, 1'b1);
    step(OP_SW, 5'd4, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 1'b1);
    chk("bubble_total5", int'(o_bubble_count), 5);

    // memory busy for three cycles
    for (int i = 0; i < 3; i++)
      step(OP_R, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    step(OP_R, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    chk("freeze_total3", int'(o_freeze_count), 3);
    idle();

    // load-use while memory busy: no bubble until release
    step(OP_R, 5'd2, 5'd3, 1'b1, 1'b1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
    step(OP_R, 5'd2, 5'd3, 1'b1, 1'b1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
    step(OP_R, 5'd2, 5'd3, 1'b1, 1'b1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1);
    chk("frz_then_bubble", int'(o_bubble_count), 6);

    // timeout: stays frozen even once memory answers; freeze counter saturates
    for (int i = 0; i < 20; i++)
      step(OP_R, 5'd2, 5'd3, 1'b1, 1'b1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
    step(OP_R, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    chk("timeout_sticky", int'(o_mem_timeout), 1);
    chk("timeout_frozen", int'(o_pipe_freeze), 1);
    chk("freeze_saturated", int'(o_freeze_count), CMAX);
    do_reset("rst_to");
    idle();

    // reset in the middle of a memory wait returns to run
    step(OP_R, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    step(OP_R, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    do_reset("rst_wait");
    idle();

    // random traffic with periodic resets
    for (int n = 0; n < 400; n++) begin
      if (n % 80 == 79) do_reset("rst_rand");
      step(ops[$urandom_range(0, 4)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0));
    end

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
